posit_add_result_fifo: RTL and testbench

POSIT_ADD_RESULT_FIFO -- requirements
Module: posit_add_result_fifo

---
 rtl/posit_add_result_fifo.sv | 92 +++++++++
 tb/tb_posit_add_result_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_result_fifo.sv
// Result FIFO behind a 5-stage posit adder.
// Issue is credit-gated: occupancy plus in-flight results never exceeds DEPTH.
module posit_add_result_fifo #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_req,
    output logic          start,
    input  logic          done,
    input  logic [N-1:0]  out,
    input  logic          inf,
    input  logic          zero,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_out,
    output logic          res_inf,
    output logic          res_zero,
    output logic [AW:0]   count,
    output logic          ovf_err
);

    localparam logic [AW:0]   DepthC = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DepthS = (AW+2)'(DEPTH);

    logic [N+1:0]  mem [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   count_q, count_d, infl_q, infl_d;
    logic          ovf_q, ovf_d;
    logic          done_acc, full, rd, wr;
    logic [AW+1:0] occ;

    always_comb begin
        occ       = {1'b0, count_q} + {1'b0, infl_q};
        // A slot freed by a read this cycle is not yet usable as credit.
        start     = start_req & ~rst & (occ < DepthS);
        // The adder has no reset, so results with nothing in flight are stale.
        done_acc  = done & (infl_q != '0);
        full      = (count_q == DepthC);
        res_valid = (count_q != '0) & ~rst;
        rd        = res_valid & res_ready;
        wr        = done_acc & (~full | rd);
        wp_d      = wr ? wp_q + AW'(1) : wp_q;
        rp_d      = rd ? rp_q + AW'(1) : rp_q;
        ovf_d     = ovf_q | (done_acc & full & ~rd);

        count_d = count_q;
        unique case ({wr, rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        infl_d = infl_q;
        unique case ({start, done_acc})
            2'b10:   infl_d = infl_q + (AW+1)'(1);
            2'b01:   infl_d = infl_q - (AW+1)'(1);
            default: infl_d = infl_q;
        endcase

        {res_inf, res_zero, res_out} = mem[rp_q];
    end

    assign count   = count_q;
    assign ovf_err = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            infl_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            infl_q  <= infl_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp_q] <= {inf, zero, out};
        end
    end

endmodule

// File: tb/tb_posit_add_result_fifo.sv
// Scoreboard bench: a 5-stage adder model feeds the FIFO, a monitor checks every read in order.
module tb_posit_add_result_fifo;

    typedef struct packed {
        logic        inf;
        logic        zero;
        logic [31:0] out;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, start_req, start, done, inf, zero;
    logic [31:0] out;
    logic        res_valid, res_ready, res_inf, res_zero, ovf_err;
    logic [31:0] res_out;
    logic [3:0]  count;

    logic        force_en = 1'b0;
    logic        f_done   = 1'b0;
    res_t        f_res    = '0;
    logic [4:0]  pipe_v   = '0;
    res_t        pipe_d [5];
    int          n_issued = 0;
    int          n_reads  = 0;
    int          checks   = 0;
    int          errors   = 0;
    res_t        exp_q [$];

    always #5 clk = ~clk;

    posit_add_result_fifo #(.N(32), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req),
        .start     (start),
        .done      (done),
        .out       (out),
        .inf       (inf),
        .zero      (zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_inf   (res_inf),
        .res_zero  (res_zero),
        .count     (count),
        .ovf_err   (ovf_err)
    );

    // Hand-computed posit32 (es=2) sums, indexed by issue order modulo 8.
    function automatic res_t get_vec(input int i);
        case (i % 8)
            0:       return {1'b0, 1'b0, 32'h4800_0000}; // 1.0 + 1.0 = 2.0
            1:       return {1'b0, 1'b1, 32'h0000_0000}; // 1.0 + -1.0 = 0
            2:       return {1'b1, 1'b0, 32'h8000_0000}; // NaR + 1.0 = NaR
            3:       return {1'b0, 1'b0, 32'h5000_0000}; // 2.0 + 2.0 = 4.0
            4:       return {1'b0, 1'b0, 32'h4000_0000}; // 0.5 + 0.5 = 1.0
            5:       return {1'b0, 1'b0, 32'h4C00_0000}; // 1.0 + 2.0 = 3.0
            6:       return {1'b0, 1'b0, 32'h5800_0000}; // 4.0 + 4.0 = 8.0
            default: return {1'b0, 1'b0, 32'h4400_0000}; // 1.0 + 0.5 = 1.5
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Adder model: fixed 5-cycle latency, no reset.
    assign done = force_en ? f_done : pipe_v[4];
    assign {inf, zero, out} = force_en ? f_res : pipe_d[4];

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[3:0], start};
        pipe_d[0] <= get_vec(n_issued);
        for (int i = 1; i < 5; i++) pipe_d[i] <= pipe_d[i-1];
        if (start) begin
            n_issued <= n_issued + 1;
            if (!force_en) exp_q.push_back(get_vec(n_issued));
        end
    end

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            n_reads <= n_reads + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_read", {res_inf, res_zero, res_out}, 64'h0);
                if ({res_inf, res_zero, res_out} == 34'h0) begin
                    errors++;
                    $display("FAIL unexpected_read: got read expected none at %0t", $time);
                end
            end else begin
                chk("head", {30'h0, res_inf, res_zero, res_out}, {30'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   base;
        res_t r;
        rst = 1'b1; start_req = 1'b1; res_ready = 1'b0;
        #1;
        chk("start_in_rst", start, 0);
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_start", start, 0);
        start_req = 1'b0; rst = 1'b0;
        tick();

        // Single op and issue-to-head latency.
        start_req = 1'b1; #1;
        chk("single_start", start, 1);
        tick();
        start_req = 1'b0;
        chk("single_issued", n_issued, 1);
        repeat (4) begin
            chk("valid_early", res_valid, 0);
            tick();
        end
        chk("done_latency", done, 1);
        chk("valid_before_write", res_valid, 0);
        tick();
        chk("single_valid", res_valid, 1);
        chk("single_count", count, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_drained", count, 0);
        chk("single_valid_low", res_valid, 0);

        // Backpressure: exactly DEPTH grants.
        base = n_issued;
        start_req = 1'b1;
        repeat (20) tick();
        chk("bp_grants", n_issued - base, 8);
        chk("bp_start_low", start, 0);
        chk("bp_count", count, 8);
        chk("bp_ovf", ovf_err, 0);

        // Read while full: no same-cycle credit, one regrant next cycle.
        base = n_issued;
        res_ready = 1'b1; #1;
        chk("full_read_no_credit", start, 0);
        tick();
        res_ready = 1'b0;
        chk("full_read_count", count, 7);
        chk("regrant", start, 1);
        tick();
        chk("regrant_once", start, 0);
        repeat (4) tick();
        chk("refill_early", count, 7);
        tick();
        chk("refill_count", count, 8);
        chk("regrant_total", n_issued - base, 1);
        start_req = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 40 && count != 0; k++) tick();
        res_ready = 1'b0;
        chk("drain1_count", count, 0);

        // Reset mid-flight: stale done pulses must be discarded.
        base = n_issued;
        start_req = 1'b1;
        repeat (3) tick();
        start_req = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        chk("midflight_issued", n_issued - base, 3);
        tick();
        rst = 1'b0;
        repeat (10) begin
            chk("stale_valid", res_valid, 0);
            tick();
        end
        chk("stale_count", count, 0);
        chk("stale_ovf", ovf_err, 0);

        // Forced overflow: bench drives done directly.
        force_en = 1'b1;
        base = n_issued;
        start_req = 1'b1;
        repeat (8) tick();
        start_req = 1'b0;
        chk("force_grants", n_issued - base, 8);
        for (int i = 0; i < 8; i++) begin
            f_done = 1'b1;
            f_res  = get_vec(7 - i);
            exp_q.push_back(f_res);
            tick();
        end
        f_done = 1'b0;
        chk("force_full", count, 8);
        chk("force_no_ovf", ovf_err, 0);
        force dut.infl_q = 4'd1;
        f_done = 1'b1;
        f_res  = {1'b1, 1'b1, 32'hDEAD_BEEF};
        tick();
        f_done = 1'b0;
        chk("ovf_set", ovf_err, 1);
        chk("ovf_count", count, 8);
        r = get_vec(7);
        chk("ovf_head", {res_inf, res_zero, res_out}, {30'h0, r});
        tick(); tick();
        chk("ovf_sticky", ovf_err, 1);
        f_done = 1'b1;
        f_res  = get_vec(0);
        exp_q.push_back(f_res);
        res_ready = 1'b1;
        tick();
        f_done = 1'b0;
        res_ready = 1'b0;
        chk("full_rw_count", count, 8);
        release dut.infl_q;
        res_ready = 1'b1;
        for (int k = 0; k < 40 && count != 0; k++) tick();
        res_ready = 1'b0;
        chk("drain2_count", count, 0);
        chk("ovf_held", ovf_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_en = 1'b0;
        chk("ovf_cleared", ovf_err, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_reads", n_reads, 19);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
